// File: rtl/axi4_lite_master_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// axi4_lite_master_bridge: native valid/ready memory request to AXI4-lite master, one transaction in flight.
// Optional watchdog abort when AXI_BRIDGE_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module axi4_lite_master_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        instr_q, instr_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef AXI_BRIDGE_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        instr_d   = instr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    if (|mem_wstrb) begin
                        state_d   = WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WADDR: begin
                // AW and W retire independently; move on once neither is outstanding
                if (awvalid_q && mem_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && mem_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (mem_axi_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                    ready_d  = 1'b1;
                end
            end
            RADDR: begin
                if (mem_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (mem_axi_rvalid) begin
                    rdata_d  = mem_axi_rdata;
                    rready_d = 1'b0;
                    state_d  = DONE;
                    ready_d  = 1'b1;
                end
            end
            DONE: begin
                // mem_valid deliberately ignored here so a held request is not re-issued
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_BRIDGE_TIMEOUT_EN
        cnt_d = '0;
        if (state_q != IDLE && state_q != DONE) begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_d == 32'(TIMEOUT_CYCLES - 1)) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = DONE;
                ready_d   = 1'b1;
                err_d     = 1'b1;
                rdata_d   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            instr_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            instr_q   <= instr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef AXI_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`endif

    assign mem_ready       = ready_q;
    assign mem_rdata       = rdata_q;
    assign mem_err         = err_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = addr_q;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = addr_q;
    assign mem_axi_arprot  = {instr_q, 2'b00};
    assign mem_axi_rready  = rready_q;
endmodule
`default_nettype wire
